// File: rtl/seg_scan6.sv
// seg_scan6: six-digit multiplexed 7-segment driver.
// The six BCD digit buses share one segment bus, and one digit is lit at a time.
// A shadow copy of the digits and masks is taken once per frame, so a digit that
// changes mid-frame never produces a torn display.
// The driver also handles leading-zero blanking, per-digit decimal points and
// per-digit blink.
module seg_scan6 #(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 64,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit DIG_ACT_LOW  = 1'b1
) (
    input  logic       fs,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    input  logic [3:0] d,
    input  logic [3:0] e,
    input  logic [3:0] f,
    input  logic [5:0] dp_mask,
    input  logic [5:0] blink_mask,
    input  logic       lz_blank,
    output logic [7:0] seg,
    output logic [5:0] dig,
    output logic       frame_tick
);

    localparam int             PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);
    localparam int             FW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0]  FC_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [7:0]     SEG_OFF  = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [5:0]     DIG_OFF  = DIG_ACT_LOW ? 6'h3F : 6'h00;

    logic [PW-1:0]     pre_q, pre_d;
    logic [2:0]        idx_q, idx_d;
    logic [5:0][3:0]   sh_dig_q, sh_dig_d;
    logic [5:0]        sh_dp_q, sh_dp_d;
    logic [5:0]        sh_blink_q, sh_blink_d;
    logic              sh_lz_q, sh_lz_d;
    logic              sh_phase_q, sh_phase_d;
    logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
    logic              phase_q, phase_d;
    logic              frame_tick_q, frame_tick_d;
    logic [7:0]        seg_q, seg_d;
    logic [5:0]        dig_q, dig_d;

    logic              load;
    logic [5:0]        lz_hit;
    logic [3:0]        cur_code;
    logic              cur_dp;
    logic              cur_blink;
    logic              cur_lz;
    logic [5:0]        cur_sel;
    logic [7:0]        seg_log;
    logic [5:0]        dig_log;

    // Logical gfedcba pattern for one BCD code; codes 10..15 show a dash.
    function automatic logic [6:0] decode7(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        return pat;
    endfunction

    assign load = (pre_q == '0) && (idx_q == 3'd0);

    // Slot prescaler and digit index: SCAN_DIV cycles per slot, six slots per frame.
    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Shadow load at the start of every frame; the blink phase is sampled too so a
    // phase flip can never land in the middle of a frame.
    always_comb begin
        sh_dig_d   = sh_dig_q;
        sh_dp_d    = sh_dp_q;
        sh_blink_d = sh_blink_q;
        sh_lz_d    = sh_lz_q;
        sh_phase_d = sh_phase_q;
        if (load) begin
            sh_dig_d   = {f, e, d, c, b, a};
            sh_dp_d    = dp_mask;
            sh_blink_d = blink_mask;
            sh_lz_d    = lz_blank;
            sh_phase_d = phase_q;
        end
    end

    // Blink timebase: count frames on each frame tick and flip phase at wrap.
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        phase_d      = phase_q;
        frame_tick_d = load;
        if (frame_tick_q) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Leading-zero chain: a digit blanks only if it and all higher digits are zero.
    always_comb begin
        lz_hit    = '0;
        lz_hit[5] = sh_lz_q && (sh_dig_q[5] == 4'd0);
        for (int i = 4; i >= 1; i--) begin
            lz_hit[i] = lz_hit[i+1] && (sh_dig_q[i] == 4'd0);
        end
    end

    // Select the shadow fields for the digit currently being scanned.
    always_comb begin
        cur_code  = '0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        cur_sel   = '0;
        for (int i = 0; i < 6; i++) begin
            if (idx_q == 3'(i)) begin
                cur_code   = sh_dig_q[i];
                cur_dp     = sh_dp_q[i];
                cur_blink  = sh_blink_q[i];
                cur_lz     = lz_hit[i];
                cur_sel[i] = 1'b1;
            end
        end
    end

    // Logical output pattern, including the guard cycle, then the output polarity.
    always_comb begin
        seg_log = {cur_dp, decode7(cur_code)};
        dig_log = cur_sel;
        if (cur_lz || (sh_phase_q && cur_blink)) begin
            seg_log = '0;
        end
        if (pre_q == '0) begin
            seg_log = '0;
            dig_log = '0;
        end
        seg_d = seg_log ^ SEG_OFF;
        dig_d = dig_log ^ DIG_OFF;
    end

    // State registers; reset drives the display dark immediately.
    always_ff @(posedge fs or negedge rst_n) begin
        if (!rst_n) begin
            pre_q        <= '0;
            idx_q        <= '0;
            sh_dig_q     <= '0;
            sh_dp_q      <= '0;
            sh_blink_q   <= '0;
            sh_lz_q      <= 1'b0;
            sh_phase_q   <= 1'b0;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dig_q        <= DIG_OFF;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            sh_dig_q     <= sh_dig_d;
            sh_dp_q      <= sh_dp_d;
            sh_blink_q   <= sh_blink_d;
            sh_lz_q      <= sh_lz_d;
            sh_phase_q   <= sh_phase_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
            frame_tick_q <= frame_tick_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
        end
    end

    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan6.sv
// tb_seg_scan6: directed vectors for the six-digit scan driver
// (SCAN_DIV=4, BLINK_FRAMES=2, active-low segments and digit selects).
module tb_seg_scan6;

    logic       fs = 1'b0;
    logic       rst_n;
    logic [3:0] a, b, c, d, e, f;
    logic [5:0] dp_mask;
    logic [5:0] blink_mask;
    logic       lz_blank;
    logic [7:0] seg;
    logic [5:0] dig;
    logic       frame_tick;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0][3:0] digits;
        logic [5:0]      dp;
        logic [5:0]      blink;
        logic            lz;
        logic [5:0][7:0] expSeg;
    } vec_t;

    vec_t vecs[7];

    seg_scan6 #(
        .SCAN_DIV    (4),
        .BLINK_FRAMES(2),
        .SEG_ACT_LOW (1'b1),
        .DIG_ACT_LOW (1'b1)
    ) dut (
        .fs        (fs),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .dp_mask   (dp_mask),
        .blink_mask(blink_mask),
        .lz_blank  (lz_blank),
        .seg       (seg),
        .dig       (dig),
        .frame_tick(frame_tick)
    );

    // 100 MHz-style scan clock
    always #5 fs = ~fs;

    // Watchdog so a stuck run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepEdges(input int n);
        repeat (n) begin
            @(posedge fs);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [5:0][3:0] digits, input logic [5:0] dp,
                                 input logic [5:0] blink, input logic lz);
        a          = digits[0];
        b          = digits[1];
        c          = digits[2];
        d          = digits[3];
        e          = digits[4];
        f          = digits[5];
        dp_mask    = dp;
        blink_mask = blink;
        lz_blank   = lz;
    endtask

    // Hold reset for two edges and release between edges, so the next edge is E1
    task automatic restartFrame();
        rst_n = 1'b0;
        stepEdges(2);
        rst_n = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expSeg, input logic [5:0] expDig);
        checks++;
        if (seg !== expSeg || dig !== expDig) begin
            failures++;
            $display("[TB] FAIL %s: got seg=%h dig=%h, expected seg=%h dig=%h", name, seg, dig, expSeg, expDig);
        end
    endtask

    task automatic checkTick(input string name, input logic expTick);
        checks++;
        if (frame_tick !== expTick) begin
            failures++;
            $display("[TB] FAIL %s: got frame_tick=%b, expected %b", name, frame_tick, expTick);
        end
    endtask

    // After edge n since release: counters held (n-1), so slot pre=(n-1)%4 of digit ((n-1)/4)%6
    task automatic checkSlot(input string tag, input int n, input logic [5:0][7:0] expSeg);
        int         p;
        int         i;
        logic [5:0] oh;
        p  = (n - 1) % 4;
        i  = ((n - 1) / 4) % 6;
        oh = 6'b000001 << i;
        if (p == 0) checkOutput($sformatf("%s_n%0d_guard", tag, n), 8'hFF, 6'h3F);
        else        checkOutput($sformatf("%s_n%0d_d%0d", tag, n, i), expSeg[i], ~oh);
    endtask

    task automatic waitFrameTick(input string name);
        int cnt;
        cnt = 0;
        stepEdges(1);
        while (frame_tick !== 1'b1 && cnt < 30) begin
            stepEdges(1);
            cnt++;
        end
        if (frame_tick !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: frame_tick not seen, got %b expected 1", name, frame_tick);
        end
    endtask

    initial begin
        logic [5:0][7:0] v0Exp;
        logic [5:0][7:0] v0Changed;
        logic [7:0]      exp0;
        logic [7:0]      exp1;
        bit              off;

        // {digit5 .. digit0}; expected segments are active-low
        vecs[0] = '{digits: {4'd0, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, dp: 6'b0, blink: 6'b0, lz: 1'b0,
                    expSeg: {8'hC0, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9}};
        vecs[1] = '{digits: {4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0}, dp: 6'b0, blink: 6'b0, lz: 1'b1,
                    expSeg: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hB0, 8'hC0}};
        vecs[2] = '{digits: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, dp: 6'b0, blink: 6'b0, lz: 1'b1,
                    expSeg: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[3] = '{digits: {4'd0, 4'd7, 4'd6, 4'hA, 4'd9, 4'd8}, dp: 6'b0, blink: 6'b0, lz: 1'b0,
                    expSeg: {8'hC0, 8'hF8, 8'h82, 8'hBF, 8'h90, 8'h80}};
        vecs[4] = '{digits: {4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0}, dp: 6'b000100, blink: 6'b0, lz: 1'b0,
                    expSeg: {8'hC0, 8'hC0, 8'hC0, 8'h30, 8'hC0, 8'hC0}};
        vecs[5] = '{digits: {4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0}, dp: 6'b100001, blink: 6'b0, lz: 1'b1,
                    expSeg: {8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0, 8'h40}};
        vecs[6] = '{digits: {4'hF, 4'hB, 4'hC, 4'hD, 4'hE, 4'd0}, dp: 6'b0, blink: 6'b111111, lz: 1'b1,
                    expSeg: {8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hC0}};
        v0Exp     = vecs[0].expSeg;
        v0Changed = v0Exp;
        v0Changed[0] = 8'hF8;

        rst_n = 1'b0;
        applyStimulus(vecs[0].digits, 6'b0, 6'b0, 1'b0);
        stepEdges(1);
        checkOutput("reset_state", 8'hFF, 6'h3F);
        checkTick("reset_tick", 1'b0);

        // Table: each vector gets a fresh frame and a full 24-cycle frame check
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].digits, vecs[v].dp, vecs[v].blink, vecs[v].lz);
            restartFrame();
            for (int n = 1; n <= 24; n++) begin
                stepEdges(1);
                if (n == 1) checkTick($sformatf("v%0d_tick_e1", v), 1'b1);
                if (n == 2) checkTick($sformatf("v%0d_tick_e2", v), 1'b0);
                checkSlot($sformatf("v%0d", v), n, vecs[v].expSeg);
            end
        end

        // Asynchronous reset in the middle of digit 3's slot
        applyStimulus(vecs[0].digits, 6'b0, 6'b0, 1'b0);
        restartFrame();
        stepEdges(14);
        checkOutput("pre_reset_d3", 8'h99, 6'h37);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 8'hFF, 6'h3F);
        checkTick("async_reset_tick", 1'b0);
        stepEdges(2);
        checkOutput("held_reset", 8'hFF, 6'h3F);
        rst_n = 1'b1;
        stepEdges(1);
        checkTick("release_tick_e1", 1'b1);
        checkOutput("release_guard_e1", 8'hFF, 6'h3F);
        stepEdges(1);
        checkTick("release_tick_e2", 1'b0);
        checkOutput("release_d0_e2", 8'hF9, 6'h3E);

        // Mid-frame change of digit a only shows from the next frame
        restartFrame();
        stepEdges(14);
        a = 4'd7;
        for (int n = 15; n <= 24; n++) begin
            stepEdges(1);
            checkSlot("midchg_f0", n, v0Exp);
        end
        stepEdges(1);
        checkTick("midchg_tick_e25", 1'b1);
        for (int n = 26; n <= 30; n++) begin
            stepEdges(1);
            checkSlot("midchg_f1", n, v0Changed);
        end

        // Blink with BLINK_FRAMES=2: digits 0,1 dark in frames 2,3,6,7
        applyStimulus(vecs[0].digits, 6'b0, 6'b000011, 1'b0);
        restartFrame();
        for (int k = 0; k < 8; k++) begin
            waitFrameTick($sformatf("blink_f%0d_tick", k));
            off  = ((k / 2) % 2) == 1;
            exp0 = off ? 8'hFF : 8'hF9;
            exp1 = off ? 8'hFF : 8'hA4;
            stepEdges(1);
            checkOutput($sformatf("blink_f%0d_d0", k), exp0, 6'h3E);
            stepEdges(4);
            checkOutput($sformatf("blink_f%0d_d1", k), exp1, 6'h3D);
            stepEdges(4);
            checkOutput($sformatf("blink_f%0d_d2", k), 8'hB0, 6'h3B);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
